// File: rtl/au_add_chunk_serial.sv
// Chunk-serial adder: CHUNK bits per clock through one combinational prefix unit,
// with a ready/valid handshake on both the operand and the result side.

// Group generate/propagate over bits [i:0] of a CHUNK-wide slice.
// ARCH == 1 selects a log-depth Kogge-Stone network; any other value ripples.
module au_prefix_and_or #(
  parameter int N    = 8,
  parameter int ARCH = 0
) (
  input  logic [N-1:0] gi,
  input  logic [N-1:0] pi,
  output logic [N-1:0] go,
  output logic [N-1:0] po
);

  if (ARCH == 1) begin : g_kogge_stone
    always_comb begin
      logic [N-1:0] g_t, p_t, g_n, p_n;
      // NOTE: blocking assignments here build a combinational chain of intermediate
      // levels; every output is fully assigned on every path, so nothing latches.
      g_t = gi;
      p_t = pi;
      for (int d = 1; d < N; d = d * 2) begin
        g_n = g_t;
        p_n = p_t;
        for (int i = d; i < N; i++) begin
          g_n[i] = g_t[i] | (p_t[i] & g_t[i-d]);
          p_n[i] = p_t[i] & p_t[i-d];
        end
        g_t = g_n;
        p_t = p_n;
      end
      go = g_t;
      po = p_t;
    end
  end else begin : g_ripple
    always_comb begin
      logic [N-1:0] g_r, p_r;
      g_r[0] = gi[0];
      p_r[0] = pi[0];
      for (int i = 1; i < N; i++) begin
        g_r[i] = gi[i] | (pi[i] & g_r[i-1]);
        p_r[i] = pi[i] & p_r[i-1];
      end
      go = g_r;
      po = p_r;
    end
  end

endmodule

module au_add_chunk_serial #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int ARCH  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("au_add_chunk_serial: CHUNK must be >= 1 and divide WIDTH");
  end

  localparam int NC = WIDTH / CHUNK;
  localparam int KW = (NC > 1) ? $clog2(NC) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic [KW-1:0]     k;
  logic              c;
  logic [WIDTH-1:0]  a_q, b_q;

  logic [CHUNK-1:0]  ga, gb, gi, pi, go, po, sum_c;
  logic [CHUNK:0]    cy;
  logic              last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign last      = (k == KW'(NC - 1));

  assign ga = a_q[k*CHUNK +: CHUNK];
  assign gb = b_q[k*CHUNK +: CHUNK];
  assign gi = ga & gb;
  assign pi = ga ^ gb;

  au_prefix_and_or #(.N(CHUNK), .ARCH(ARCH)) u_prefix (
    .gi (gi),
    .pi (pi),
    .go (go),
    .po (po)
  );

  // The prefix outputs are relative to a zero carry-in; fold the running carry in here.
  always_comb begin
    cy[0] = c;
    for (int i = 0; i < CHUNK; i++) begin
      cy[i+1] = go[i] | (po[i] & c);
    end
    sum_c = pi ^ cy[CHUNK-1:0];
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = BUSY;
      BUSY:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand holding registers are reset too, so an aborted operation leaves no trace.
      k   <= '0;
      c   <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      s   <= '0;
      co  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q <= a;
          b_q <= b;
          c   <= ci;
          k   <= '0;
        end
        BUSY: begin
          s[k*CHUNK +: CHUNK] <= sum_c;
          c <= cy[CHUNK];
          if (last) co <= cy[CHUNK];
          else      k  <= k + KW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
